// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock distributed-RAM FIFO family:
// sizing helpers, defaults and elaboration-time parameter range checks.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_RANGE_CHECK(P, LO, HI, LBL) \
    if (((P) < (LO)) || ((P) > (HI))) begin : LBL \
        $error("parameter out of range"); \
    end

`define FIFO_MAX_CHECK(P, HI, LBL) \
    if ((P) > (HI)) begin : LBL \
        $error("parameter out of range"); \
    end

package fifo_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // One extra bit so a full RAM plus the output stage fits in level.
    function automatic int unsigned level_w_of(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

`endif

// File: rtl/sdpram_core_sc.sv
// Single-clock storage array: one synchronous write port, one asynchronous
// read port, no reset, so synthesis can map it onto distributed LUT RAM.
module sdpram_core_sc
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_c
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_dram.sv
// Single-clock FIFO over distributed RAM with valid/ready handshakes, optional
// registered FWFT output stage, level reporting, almost-flags and flush.
module sync_fifo_dram
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned OUT_REG    = 1,
    parameter int unsigned AF_LEVEL   = (32'd1 << ADDR_WIDTH) - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int unsigned DEPTH   = depth_of(ADDR_WIDTH);
    localparam int unsigned LEVEL_W = level_w_of(ADDR_WIDTH);

    `FIFO_RANGE_CHECK(ADDR_WIDTH, 4, 10, g_range_addr_width)
    `FIFO_RANGE_CHECK(DATA_WIDTH, 1, 256, g_range_data_width)
    `FIFO_MAX_CHECK(OUT_REG, 1, g_max_out_reg)

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]    mcount_q, mcount_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic [DATA_WIDTH-1:0] st_data_q, st_data_d;
    logic                  st_valid_q, st_valid_d;
    logic                  ram_we, ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  push, pop;

    sdpram_core_sc #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .waddr_i(wr_ptr_q),
        .wdata_i(s_data),
        .raddr_i(rd_ptr_q),
        .rdata_c(ram_rdata)
    );

    // Ready depends only on registered RAM occupancy, never on m_ready.
    assign s_ready = (mcount_q != LEVEL_W'(DEPTH));
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    if (OUT_REG != 0) begin : g_out_reg
        assign m_valid = st_valid_q;
        assign m_data  = st_data_q;
    end else begin : g_out_comb
        assign m_valid = (mcount_q != '0);
        assign m_data  = m_valid ? ram_rdata : '0;
    end

    assign level        = level_q;
    assign almost_full  = (level_q >= LEVEL_W'(AF_LEVEL));
    assign almost_empty = (level_q <= LEVEL_W'(AE_LEVEL));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mcount_d   = mcount_q;
        level_d    = level_q;
        st_data_d  = st_data_q;
        st_valid_d = st_valid_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            mcount_d   = '0;
            level_d    = '0;
            st_data_d  = '0;
            st_valid_d = 1'b0;
        end else begin
            if (OUT_REG != 0) begin
                ram_we = push;
                // Stage refills from RAM first; an empty RAM lets a push bypass it.
                if (!st_valid_q || pop) begin
                    if (mcount_q != '0) begin
                        st_data_d  = ram_rdata;
                        st_valid_d = 1'b1;
                        ram_re     = 1'b1;
                    end else if (push) begin
                        st_data_d  = s_data;
                        st_valid_d = 1'b1;
                        ram_we     = 1'b0;
                    end else begin
                        st_valid_d = 1'b0;
                    end
                end
            end else begin
                ram_we = push;
                ram_re = pop;
            end
            if (ram_we) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (ram_re) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end
            mcount_d = mcount_q + LEVEL_W'(ram_we) - LEVEL_W'(ram_re);
            level_d  = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mcount_q   <= '0;
            level_q    <= '0;
            st_data_q  <= '0;
            st_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mcount_q   <= mcount_d;
            level_q    <= level_d;
            st_data_q  <= st_data_d;
            st_valid_q <= st_valid_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_dram.sv
// Bench for sync_fifo_dram: OUT_REG=1 and OUT_REG=0 instances share stimulus,
// each checked every cycle against a queue model plus directed literals.
module tb_sync_fifo_dram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       m_ready = 1'b0;

    logic       s_ready1, m_valid1, af1, ae1;
    logic [7:0] m_data1;
    logic [4:0] level1;
    logic       s_ready0, m_valid0, af0, ae0;
    logic [7:0] m_data0;
    logic [4:0] level0;

    int checks = 0;
    int errors = 0;

    logic [7:0] q1[$];
    logic [7:0] q0[$];

    sync_fifo_dram #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready1), .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready),
        .level(level1), .almost_full(af1), .almost_empty(ae1));

    sync_fifo_dram #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready0), .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready),
        .level(level0), .almost_full(af0), .almost_empty(ae0));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the FIFO is an ordered list of words; capacity is 16 RAM words
    // plus one more when the output stage exists.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            q1.delete();
            q0.delete();
        end else begin
            logic ps1, pp1, ps0, pp0;
            ps1 = s_valid && (q1.size() < 17);
            pp1 = m_ready && (q1.size() > 0);
            ps0 = s_valid && (q0.size() < 16);
            pp0 = m_ready && (q0.size() > 0);
            if (pp1) void'(q1.pop_front());
            if (ps1) q1.push_back(s_data);
            if (pp0) void'(q0.pop_front());
            if (ps0) q0.push_back(s_data);
        end
    end

    task automatic cmp_dut(input string tag, input int cap, input int n, input logic [7:0] head,
                           input logic srdy, input logic mval, input logic [7:0] mdat,
                           input logic [4:0] lvl, input logic af, input logic ae);
        chk({tag, ".s_ready"}, 32'(srdy), 32'(n < cap));
        chk({tag, ".m_valid"}, 32'(mval), 32'(n != 0));
        if (n != 0) chk({tag, ".m_data"}, 32'(mdat), 32'(head));
        chk({tag, ".level"}, 32'(lvl), 32'(n));
        chk({tag, ".almost_full"}, 32'(af), 32'(n >= 14));
        chk({tag, ".almost_empty"}, 32'(ae), 32'(n <= 2));
    endtask

    always @(negedge clk) begin
        logic [7:0] h1, h0;
        h1 = (q1.size() != 0) ? q1[0] : 8'h00;
        h0 = (q0.size() != 0) ? q0[0] : 8'h00;
        cmp_dut("r1", 17, q1.size(), h1, s_ready1, m_valid1, m_data1, level1, af1, ae1);
        cmp_dut("r0", 16, q0.size(), h0, s_ready0, m_valid0, m_data0, level0, af0, ae0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_empty_zero(input string tag);
        chk({tag, ".r1.level"}, 32'(level1), 32'd0);
        chk({tag, ".r1.m_valid"}, 32'(m_valid1), 32'd0);
        chk({tag, ".r1.s_ready"}, 32'(s_ready1), 32'd1);
        chk({tag, ".r1.m_data"}, 32'(m_data1), 32'd0);
        chk({tag, ".r1.ae"}, 32'(ae1), 32'd1);
        chk({tag, ".r1.af"}, 32'(af1), 32'd0);
        chk({tag, ".r0.level"}, 32'(level0), 32'd0);
        chk({tag, ".r0.m_data"}, 32'(m_data0), 32'd0);
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        m_ready = 1'b0;
        chk("drain.level", 32'(level1), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk_empty_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: fill to capacity with the consumer stalled, then drain in order
        for (int k = 0; k < 17; k++) begin
            s_valid = 1'b1;
            s_data  = 8'(k);
            tick();
            chk("fill.level", 32'(level1), 32'(k + 1));
            chk("fill.af", 32'(af1), 32'(k + 1 >= 14));
        end
        s_valid = 1'b0;
        chk("fill.s_ready", 32'(s_ready1), 32'd0);
        chk("fill.r0.level", 32'(level0), 32'd16);
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            chk("drain.m_valid", 32'(m_valid1), 32'd1);
            chk("drain.m_data", 32'(m_data1), 32'(i));
            tick();
        end
        m_ready = 1'b0;
        tick();
        chk("drain.level", 32'(level1), 32'd0);
        chk("drain.ae", 32'(ae1), 32'd1);
        chk("drain.m_valid", 32'(m_valid1), 32'd0);

        // 2: single-word latency in both output modes
        s_valid = 1'b1;
        s_data  = 8'hA5;
        tick();
        s_valid = 1'b0;
        chk("lat.r1.m_valid", 32'(m_valid1), 32'd1);
        chk("lat.r1.m_data", 32'(m_data1), 32'hA5);
        chk("lat.r0.m_valid", 32'(m_valid0), 32'd1);
        chk("lat.r0.m_data", 32'(m_data0), 32'hA5);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // 3: continuous streaming keeps one word in flight
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data = 8'(i + 8'h80);
            tick();
            chk("stream.r1.level", 32'(level1), 32'd1);
            chk("stream.r1.m_data", 32'(m_data1), 32'(8'(i + 8'h80)));
            chk("stream.r0.m_data", 32'(m_data0), 32'(8'(i + 8'h80)));
        end
        s_valid = 1'b0;
        tick();
        m_ready = 1'b0;
        chk("stream.end.level", 32'(level1), 32'd0);

        // 4: full FIFO offered pop and push together
        for (int k = 0; k < 17; k++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h40 + k);
            tick();
        end
        s_data  = 8'hEE;
        m_ready = 1'b1;
        chk("full.s_ready", 32'(s_ready1), 32'd0);
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("full.level", 32'(level1), 32'd16);
        chk("full.s_ready_next", 32'(s_ready1), 32'd1);
        chk("full.m_data", 32'(m_data1), 32'h41);
        chk("full.r0.level", 32'(level0), 32'd15);
        drain();

        // 5: random traffic across pointer wrap, checked by the model
        for (int i = 0; i < 40; i++) begin
            s_valid = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 9) < 7);
            s_data  = 8'($urandom_range(0, 255));
            tick();
        end
        drain();

        // 6: flush at level 9 with traffic offered, then reset mid-burst
        for (int k = 0; k < 9; k++) begin
            s_valid = 1'b1;
            s_data  = 8'(8'h10 + k);
            tick();
        end
        chk("clr.pre.level", 32'(level1), 32'd9);
        m_ready = 1'b1;
        clr     = 1'b1;
        tick();
        clr     = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk_empty_zero("clr");
        s_valid = 1'b1;
        s_data  = 8'h3C;
        tick();
        s_valid = 1'b0;
        chk("clr.first.r1", 32'(m_data1), 32'h3C);
        chk("clr.first.r0", 32'(m_data0), 32'h3C);
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 8'(8'h50 + i);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk_empty_zero("rst.async");
        tick();
        rst_n   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        tick();
        chk_empty_zero("rst");
        s_valid = 1'b1;
        s_data  = 8'h3C;
        tick();
        s_valid = 1'b0;
        chk("rst.first.m_valid", 32'(m_valid1), 32'd1);
        chk("rst.first.m_data", 32'(m_data1), 32'h3C);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("rst.end.level", 32'(level1), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_dram.md
Name: sync_fifo_dram

Overview:
- Single-clock, parametrised FIFO built on inferred distributed (LUT) RAM.
- It is the successor to the dual-clock distributed SDP RAM macro: it adds pointer management, valid/ready handshakes on both sides, an optional registered first-word-fall-through output stage, level reporting, programmable almost-flags and a synchronous flush.
- It sits between sample producers (ADC/filter stages) and downstream processing blocks in the signal chain.

Parameters:
- ADDR_WIDTH, 10, RAM address width (4..10); DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, word width (1..256).
- OUT_REG, 1, 0 = combinational read of the RAM head; 1 = registered output stage, which adds one word of capacity.
- AF_LEVEL, DEPTH-2, almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset; release is synchronous to clk (externally synchronised).
- clr  in  1  synchronous flush.
- s_data  in  DATA_WIDTH  write data.
- s_valid  in  1  write request.
- s_ready  out  1  FIFO can accept a word.
- m_data  out  DATA_WIDTH  head-of-FIFO data.
- m_valid  out  1  m_data holds a valid word.
- m_ready  in  1  consumer accepts the head word.
- level  out  ADDR_WIDTH+1  words currently held; includes the output stage when OUT_REG=1.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.

Behaviour:
- Definitions:
  - push = s_valid & s_ready.
  - pop = m_valid & m_ready.
  - mcount = RAM occupancy (ADDR_WIDTH+1 bits).
  - wr_ptr/rd_ptr are ADDR_WIDTH bits and wrap modulo DEPTH with no special case.
- Ready logic:
  - s_ready = (mcount != DEPTH).
  - s_ready must not depend combinationally on m_ready or s_valid.
  - When full, a same-cycle pop does not enable a push; the freed slot is usable next cycle.
- Write path: on push, mem[wr_ptr] <= s_data and wr_ptr++, except in the OUT_REG=1 bypass case below.
- OUT_REG=0:
  - m_valid = (mcount != 0); m_data = mem[rd_ptr] when m_valid, else 0.
  - pop increments rd_ptr.
  - A word pushed in cycle N is visible on m_data in cycle N+1.
- OUT_REG=1 (stage register st_data/st_valid):
  - m_valid = st_valid; m_data = st_data.
  - The stage loads when !st_valid | pop, with this priority:
    - mcount != 0: st_data <= mem[rd_ptr], rd_ptr++.
    - Else if push: st_data <= s_data (bypass). The RAM is not written and wr_ptr does not move.
    - Else: st_valid <= 0.
  - Latency from push to m_valid is one cycle, the same as OUT_REG=0.
  - Order is strictly preserved.
  - Total capacity = DEPTH+1.
- Level and flags:
  - level is a register: level <= level + push - pop. Simultaneous push and pop leave it unchanged.
  - almost_full and almost_empty are combinational compares against the registered level, so they change in the cycle after the causing handshake.
- Flush:
  - clr has priority over push and pop in the same cycle: both are ignored.
  - Pointers, mcount, level and st_valid go to 0; st_data goes to 0.
  - RAM contents are not cleared.
  - In the cycle after clr: s_ready=1, m_valid=0.
- Reset (rst_n low, asynchronous, any cycle including mid-burst):
  - Same state as clr.
  - Output values: s_ready=1, m_valid=0, m_data=0, level=0, almost_full=0, almost_empty=1.
  - RAM has no reset.
- Pop when empty is impossible (m_valid=0). Push when full is impossible (s_ready=0). No error state exists.

Decomposition:
- Shared package fifo_pkg:
  - function clog2.
  - localparams DEPTH and LEVEL_W = ADDR_WIDTH+1.
  - Parameter-range check macros used by the distributed-RAM family.
- One sub-module, sdpram_core_sc:
  - Single-clock storage array with one synchronous write port and one asynchronous read port.
  - Written so that synthesis maps it to distributed RAM.
  - No reset.
- Top level holds pointers, level, output stage, flags and handshake logic.

Test Plan:
All scenarios use ADDR_WIDTH=4 (DEPTH=16) and DATA_WIDTH=8.
1. Fill/drain, OUT_REG=1, m_ready=0: push 0x00..0x10.
   - s_ready drops after the 17th push; level=17; almost_full=1 from level 14.
   - Then m_ready=1 yields 0x00..0x10 in order, one per cycle; level returns to 0; almost_empty=1.
2. Single push into empty FIFO, OUT_REG=0 and OUT_REG=1: push 0xA5 in cycle N.
   - m_valid=1 and m_data=0xA5 in cycle N+1, in both modes.
3. Streaming with s_valid=1 and m_ready=1 continuous over 100 words: level stays at 1; throughput is one word per cycle; no reordering.
4. Full with pop and push offered the same cycle (level=17, OUT_REG=1):
   - Pop accepted; push refused; s_ready=1 next cycle; level=16.
5. Wrap-around: 40 cycles of random push/pop with a scoreboard.
   - Pointers wrap through 15→0 at least twice; data matches the model; level equals the model count every cycle.
6. clr asserted with push and pop active at level 9, then rst_n pulsed low mid-burst:
   - After each, level=0, m_valid=0, s_ready=1, m_data=0.
   - The next pushed word 0x3C is the first word popped.
